// File: rtl/binned_mem_pkg.sv
// rtl/binned_mem_pkg.sv - shared constants, state enum and address packing for the binned stub memory
package binned_mem_pkg;

  localparam int NPAGE  = 4;
  localparam int NBIN   = 8;
  localparam int NENT_W = 4;
  localparam int PAGE_W = $clog2(NPAGE);
  localparam int BIN_W  = $clog2(NBIN);
  localparam int ADDR_W = PAGE_W + BIN_W + NENT_W;
  localparam int NCNT   = NPAGE * NBIN;
  localparam logic [NENT_W-1:0] BIN_CAP = NENT_W'((1 << NENT_W) - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ACTIVE = 2'd2
  } wr_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [PAGE_W-1:0] page,
                                                  input logic [BIN_W-1:0]  bin,
                                                  input logic [NENT_W-1:0] slot);
    return {page, bin, slot};
  endfunction

endpackage

// File: rtl/binned_mem_write_ctrl_if.sv
// rtl/binned_mem_write_ctrl_if.sv - stub input stream plus BRAM/counter write port bundle
// master = stub source / memory side, slave = write controller.
interface binned_mem_write_ctrl_if #(
  parameter int RAM_WIDTH = 14
);
  import binned_mem_pkg::*;

  logic                   stub_valid;
  logic                   stub_ready;
  logic [BIN_W-1:0]       stub_bin;
  logic [RAM_WIDTH-1:0]   stub_data;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [RAM_WIDTH-1:0]   mem_din;
  logic [NCNT-1:0]        nent_we;
  logic [NENT_W-1:0]      nent_din;

  modport master (
    output stub_valid, stub_bin, stub_data,
    input  stub_ready, mem_we, mem_addr, mem_din, nent_we, nent_din
  );

  modport slave (
    input  stub_valid, stub_bin, stub_data,
    output stub_ready, mem_we, mem_addr, mem_din, nent_we, nent_din
  );

endinterface

// File: rtl/binned_nent_shadow.sv
// rtl/binned_nent_shadow.sv - shadow entry counters for the bins of the active page
module binned_nent_shadow
  import binned_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  input  logic [BIN_W-1:0]  bin,
  output logic [NENT_W-1:0] cur_count,
  output logic              full
);

  logic [NENT_W-1:0] cnt_q [NBIN];
  logic [NENT_W-1:0] cnt_d [NBIN];

  assign cur_count = cnt_q[bin];
  assign full      = (cnt_q[bin] == BIN_CAP);

  always_comb begin
    for (int i = 0; i < NBIN; i++) cnt_d[i] = cnt_q[i];
    if (clear) begin
      for (int i = 0; i < NBIN; i++) cnt_d[i] = '0;
    end else if (inc && !full) begin
      cnt_d[bin] = cnt_q[bin] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBIN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NBIN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/binned_mem_write_ctrl.sv
// rtl/binned_mem_write_ctrl.sv - write sequencer for the paged, binned stub memory
// Optional active-page occupancy counter enabled by defining BINNED_WR_OCC_EN.
module binned_mem_write_ctrl
  import binned_mem_pkg::*;
#(
  parameter int RAM_WIDTH = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bx_start,
  input  logic [PAGE_W-1:0] bx_page,
  binned_mem_write_ctrl_if.slave bus,
  output logic [PAGE_W-1:0] active_page,
  output logic              busy,
  output logic [7:0]        ovf_cnt,
  output logic [6:0]        occ_total
);

  wr_state_e            state_q, state_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [RAM_WIDTH-1:0] mem_din_q, mem_din_d;
  logic [NCNT-1:0]      nent_we_q, nent_we_d;
  logic [NENT_W-1:0]    nent_din_q, nent_din_d;
  logic [7:0]           ovf_q, ovf_d;

  logic              go_clear;
  logic              stub_ready;
  logic              accept;
  logic              wr_ok;
  logic              drop;
  logic [NENT_W-1:0] cur_count;
  logic              full;

  binned_nent_shadow u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (go_clear),
    .inc       (wr_ok),
    .bin       (bus.stub_bin),
    .cur_count (cur_count),
    .full      (full)
  );

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    go_clear   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    nent_we_d  = '0;
    nent_din_d = '0;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE:    go_clear = bx_start;
      CLEAR:   state_d  = ACTIVE;
      ACTIVE:  go_clear = bx_start;
      default: state_d  = IDLE;
    endcase

    // A bx_start in ACTIVE blocks the stub so the source holds it for the new page.
    stub_ready = (state_q == ACTIVE) && !bx_start;
    accept     = bus.stub_valid && stub_ready;
    wr_ok      = accept && !full;
    drop       = accept && full;

    if (wr_ok) begin
      mem_we_d   = 1'b1;
      mem_addr_d = pack_addr(page_q, bus.stub_bin, cur_count);
      mem_din_d  = bus.stub_data;
      nent_we_d[{page_q, bus.stub_bin}] = 1'b1;
      nent_din_d = cur_count + 1'b1;
    end

    if (drop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;

    if (go_clear) begin
      state_d = CLEAR;
      page_d  = bx_page;
      nent_we_d[{bx_page, {BIN_W{1'b0}}} +: NBIN] = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      page_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      nent_we_q  <= '0;
      nent_din_q <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      nent_we_q  <= nent_we_d;
      nent_din_q <= nent_din_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef BINNED_WR_OCC_EN
  logic [6:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (go_clear)   occ_d = '0;
    else if (wr_ok) occ_d = occ_q + 7'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occ_total = occ_q;
`else
  assign occ_total = '0;
`endif

  assign bus.stub_ready = stub_ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.nent_we    = nent_we_q;
  assign bus.nent_din   = nent_din_q;
  assign active_page    = page_q;
  assign busy           = (state_q != IDLE);
  assign ovf_cnt        = ovf_q;

endmodule
